cart_bus_initiator: RTL and testbench
=====================================

Name: cart_bus_initiator

Overview:
Console-side bus master for the cartridge connector. It turns single-request transactions into I/O-port and memory read/write cycles on nSel/nIO/nOE/nWE/address/data, with parameterised phase lengths. It is the initiator counterpart of the cartridge top-level and is used in the bench harness and the MCU-side debug bridge to drive the cart bus.

Parameters:
SETUP_CYCLES, 1, cycles with nSel low and address/data stable before the strobe falls (1..15)
STROBE_CYCLES, 2, cycles with nOE or nWE low (1..15)
HOLD_CYCLES, 1, cycles with the strobe high while nSel, address and data are still held (1..15)
RECOVER_CYCLES, 1, cycles with nSel high before the next request can be accepted (1..15)

Ports:
FastClk  in  1  block clock
nReset  in  1  asynchronous active-low reset
ReqValid  in  1  request present
ReqReady  out  1  high only in IDLE; a request is accepted on an edge where ReqValid&ReqReady
ReqWrite  in  1  1=write, 0=read
ReqIO  in  1  1=I/O port access, 0=memory access
ReqWord  in  1  1=16-bit memory access; ignored (forced 0) when ReqIO=1
ReqAddr  in  20  memory address; for I/O only [7:0] is used (port number)
ReqWData  in  16  write data
RespValid  out  1  one-cycle pulse at completion (reads and writes)
RespRData  out  16  read data, valid while RespValid is high and held until the next completion
nSel, nIO, nOE, nWE  out  1 each  cart bus controls
AddrLo  out  9  bus A[8:0]
AddrHi  out  4  bus A[19:16]
DataOut  out  16  bus write data
DataOELo, DataOEHi  out  1 each  tri-state enables for DataOut[7:0] and DataOut[15:8]
DataIn  in  16  bus read data

Behaviour:
- Decided: one clock (FastClk); reset nReset is asynchronous and active-low.
- Reset values: nSel=nIO=nOE=nWE=1; AddrLo=0; AddrHi=0; DataOut=0; DataOELo=DataOEHi=0; RespValid=0; RespRData=0; ReqReady=1; state=IDLE.
- Asserting reset in any state releases all strobes and enables immediately. No RespValid is produced for the aborted cycle.
- On accept, register the whole request. A request not accepted is not captured, so ReqValid held while busy has no effect.
- Address mapping:
  - Memory: AddrLo=ReqAddr[8:0], AddrHi=ReqAddr[19:16].
  - I/O: AddrHi=port[7:4], AddrLo={5'b0,port[3:0]}.
- States: IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE. A 4-bit down-counter is loaded with the parameter value minus 1 on each state entry.
- SETUP: nSel=0; nIO=~ReqIO; address driven. For writes, DataOut and the enables are active: DataOELo=1, and DataOEHi=ReqWord.
- STROBE: read drives nOE=0; write drives nWE=0. Address, data and enables are unchanged.
- Read capture: on the clock edge ending the last STROBE cycle, RespRData takes DataIn[15:0] if ReqWord=1, otherwise {8'h00, DataIn[7:0]}.
- HOLD: nOE=nWE=1; nSel, address, DataOut and enables are held. The responder latches writes on the rising edge of nWE, so data stays stable through HOLD.
- RECOVER: nSel=1, nIO=1, DataOE*=0. RespValid=1 in the first RECOVER cycle only.
- Latency: RespValid is high exactly SETUP+STROBE+HOLD cycles after the accept edge, i.e. 4 cycles with defaults. ReqReady returns RECOVER_CYCLES after that.
- Invariants:
  - nOE and nWE are never low simultaneously.
  - DataOE* is never 1 while nOE=0.
  - DataOE* is never 1 outside SETUP/STROBE/HOLD of a write.
  - All outputs are registered, so there are no combinational glitches on the strobes.
- Back-to-back requests: at least RECOVER_CYCLES of nSel=1 between cycles. Throughput is 1 transaction per SETUP+STROBE+HOLD+RECOVER+1 cycles.
- A parameter value of 0 is illegal: an elaboration-time check fails.

Test Plan:
- I/O write: port 0xC2, data 0x5A -> nIO=0; AddrHi=0xC; AddrLo=0x002; DataOELo=1, DataOEHi=0; nWE low for 2 cycles; RespValid 4 cycles after accept; DataOut[7:0]=0x5A stable through the nWE rising edge.
- I/O read: port 0xE2, DataIn=0xAB81 -> nOE low 2 cycles; RespRData=0x0081; DataOE*=0 throughout.
- Memory word read: addr 0x2_0034, ReqWord=1, DataIn=0x1234 -> nIO=1; AddrHi=0x2; AddrLo=0x034; RespRData=0x1234.
- Back-to-back: ReqValid held high with two queued writes -> second nSel fall is no earlier than 2 cycles after the first nSel rise (RECOVER+accept); ReqValid during busy is not double-accepted (exactly 2 RespValid pulses).
- Reset mid-STROBE of a write -> nWE, nSel and DataOE* return to 1/1/0 asynchronously; no RespValid; ReqReady=1 after release.
- Parameter sweep with SETUP=3, STROBE=4, HOLD=2, RECOVER=2 -> RespValid 9 cycles after accept; nSel low for exactly 9 cycles.

Source files
------------

// File: rtl/cart_bus_initiator.sv
// Cart bus initiator: turns single requests into
// I/O and memory cycles on the cartridge connector.
module cart_bus_initiator #(
   parameter int SETUP_CYCLES   = 1,
   parameter int STROBE_CYCLES  = 2,
   parameter int HOLD_CYCLES    = 1,
   parameter int RECOVER_CYCLES = 1
) (
   input  logic        FastClk,
   input  logic        nReset,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic        ReqIO,
   input  logic        ReqWord,
   input  logic [19:0] ReqAddr,
   input  logic [15:0] ReqWData,
   output logic        RespValid,
   output logic [15:0] RespRData,
   output logic        nSel,
   output logic        nIO,
   output logic        nOE,
   output logic        nWE,
   output logic [8:0]  AddrLo,
   output logic [3:0]  AddrHi,
   output logic [15:0] DataOut,
   output logic        DataOELo,
   output logic        DataOEHi,
   input  logic [15:0] DataIn
);

   if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 ||
       STROBE_CYCLES < 1 || STROBE_CYCLES > 15 ||
       HOLD_CYCLES < 1 || HOLD_CYCLES > 15 ||
       RECOVER_CYCLES < 1 || RECOVER_CYCLES > 15) begin : g_bad_param
      $error("cart_bus_initiator: phase lengths must be 1..15");
   end

   localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, STROBE, HOLD, RECOVER
   } state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        r_write, r_io, r_word;
   logic        write_nx, io_nx, word_nx;
   logic        accept, active;
   logic [8:0]  alo_map;
   logic [3:0]  ahi_map;
   logic [15:0] rdata_cap;
   logic        unused_addr;

   assign unused_addr = ^ReqAddr[15:9];
   assign accept = ReqValid & ReqReady;
   assign alo_map = ReqIO ? {5'b0, ReqAddr[3:0]} : ReqAddr[8:0];
   assign ahi_map = ReqIO ? ReqAddr[7:4] : ReqAddr[19:16];
   assign rdata_cap = r_word ? DataIn : {8'h00, DataIn[7:0]};

   // Phase sequencing with a per-phase down-counter
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      write_nx = r_write;
      io_nx    = r_io;
      word_nx  = r_word;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nx = SETUP;
               cnt_nx   = SETUP_LD;
               write_nx = ReqWrite;
               io_nx    = ReqIO;
               word_nx  = ReqWord & ~ReqIO;
            end
         end
         SETUP: begin
            if (cnt == 4'd0) begin
               state_nx = STROBE;
               cnt_nx   = STROBE_LD;
            end else cnt_nx = cnt - 4'd1;
         end
         STROBE: begin
            if (cnt == 4'd0) begin
               state_nx = HOLD;
               cnt_nx   = HOLD_LD;
            end else cnt_nx = cnt - 4'd1;
         end
         HOLD: begin
            if (cnt == 4'd0) begin
               state_nx = RECOVER;
               cnt_nx   = RECOVER_LD;
            end else cnt_nx = cnt - 4'd1;
         end
         RECOVER: begin
            if (cnt == 4'd0) state_nx = IDLE;
            else cnt_nx = cnt - 4'd1;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign active = (state_nx == SETUP) || (state_nx == STROBE) ||
                   (state_nx == HOLD);

   // State, counter and captured request attributes
   always_ff @(posedge FastClk or negedge nReset) begin
      if (!nReset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         r_write <= 1'b0;
         r_io    <= 1'b0;
         r_word  <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         r_write <= write_nx;
         r_io    <= io_nx;
         r_word  <= word_nx;
      end
   end

   // Registered bus outputs decoded from the next state
   always_ff @(posedge FastClk or negedge nReset) begin
      if (!nReset) begin
         nSel      <= 1'b1;
         nIO       <= 1'b1;
         nOE       <= 1'b1;
         nWE       <= 1'b1;
         AddrLo    <= 9'd0;
         AddrHi    <= 4'd0;
         DataOut   <= 16'd0;
         DataOELo  <= 1'b0;
         DataOEHi  <= 1'b0;
         RespValid <= 1'b0;
         RespRData <= 16'd0;
         ReqReady  <= 1'b1;
      end else begin
         nSel     <= ~active;
         nIO      <= ~(active & io_nx);
         nOE      <= ~((state_nx == STROBE) & ~write_nx);
         nWE      <= ~((state_nx == STROBE) & write_nx);
         DataOELo <= active & write_nx;
         DataOEHi <= active & write_nx & word_nx;
         ReqReady <= (state_nx == IDLE);
         RespValid <= (state == HOLD) && (state_nx == RECOVER);
         if (accept) begin
            AddrLo <= alo_map;
            AddrHi <= ahi_map;
            if (ReqWrite) DataOut <= ReqWData;
         end
         if ((state == STROBE) && (state_nx == HOLD) && !r_write)
            RespRData <= rdata_cap;
      end
   end

endmodule

// File: tb/tb_cart_bus_initiator.sv
// Directed bench for cart_bus_initiator:
// default timing instance plus a stretched-phase instance.
module tb_cart_bus_initiator;

   logic        clk = 1'b0;
   logic        nReset;
   logic        ReqValid, v1;
   logic        ReqWrite, ReqIO, ReqWord;
   logic [19:0] ReqAddr;
   logic [15:0] ReqWData, DataIn;

   logic        ReqReady, RespValid, nSel, nIO, nOE, nWE;
   logic        DataOELo, DataOEHi;
   logic [15:0] RespRData, DataOut;
   logic [8:0]  AddrLo;
   logic [3:0]  AddrHi;

   logic        rdy_s, resp_s, nsel_s, nio_s, noe_s, nwe_s;
   logic        oelo_s, oehi_s;
   logic [15:0] rdata_s, dout_s;
   logic [8:0]  alo_s;
   logic [3:0]  ahi_s;

   always #5 clk = ~clk;

   cart_bus_initiator dut (
      .FastClk(clk), .nReset(nReset),
      .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqWrite(ReqWrite), .ReqIO(ReqIO), .ReqWord(ReqWord),
      .ReqAddr(ReqAddr), .ReqWData(ReqWData),
      .RespValid(RespValid), .RespRData(RespRData),
      .nSel(nSel), .nIO(nIO), .nOE(nOE), .nWE(nWE),
      .AddrLo(AddrLo), .AddrHi(AddrHi), .DataOut(DataOut),
      .DataOELo(DataOELo), .DataOEHi(DataOEHi), .DataIn(DataIn)
   );

   cart_bus_initiator #(
      .SETUP_CYCLES(3), .STROBE_CYCLES(4),
      .HOLD_CYCLES(2), .RECOVER_CYCLES(2)
   ) dut_s (
      .FastClk(clk), .nReset(nReset),
      .ReqValid(v1), .ReqReady(rdy_s),
      .ReqWrite(ReqWrite), .ReqIO(ReqIO), .ReqWord(ReqWord),
      .ReqAddr(ReqAddr), .ReqWData(ReqWData),
      .RespValid(resp_s), .RespRData(rdata_s),
      .nSel(nsel_s), .nIO(nio_s), .nOE(noe_s), .nWE(nwe_s),
      .AddrLo(alo_s), .AddrHi(ahi_s), .DataOut(dout_s),
      .DataOELo(oelo_s), .DataOEHi(oehi_s), .DataIn(DataIn)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int lat, we_lo, oe_lo, sel_lo, oe_bad;
   logic        nio0;
   logic [8:0]  alo0;
   logic [3:0]  ahi0;
   logic [1:0]  en0, en_rise;
   logic [15:0] dout0, dout_rise;

   task automatic wait_ready();
      for (int i = 0; i < 20 && !ReqReady; i++) begin
         @(posedge clk); #1;
      end
      chk("ready_before_req", ReqReady, 1'b1);
   endtask

   task automatic txn(input logic w, input logic io, input logic wd,
                      input logic [19:0] a, input logic [15:0] d,
                      input logic [15:0] din);
      logic prev_we;
      wait_ready();
      ReqWrite = w; ReqIO = io; ReqWord = wd;
      ReqAddr = a; ReqWData = d; DataIn = din;
      ReqValid = 1'b1;
      @(posedge clk); #1;
      ReqValid = 1'b0;
      lat = -1; we_lo = 0; oe_lo = 0; sel_lo = 0; oe_bad = 0;
      prev_we = 1'b1; dout_rise = 16'hxxxx; en_rise = 2'bxx;
      for (int k = 0; k < 40; k++) begin
         if (k == 0) begin
            nio0 = nIO; alo0 = AddrLo; ahi0 = AddrHi;
            en0 = {DataOEHi, DataOELo}; dout0 = DataOut;
         end
         if (RespValid) begin
            lat = k;
            break;
         end
         if (!nSel) sel_lo++;
         if (!nWE) we_lo++;
         if (!nOE) oe_lo++;
         if ((DataOELo || DataOEHi) && (!w || !nOE)) oe_bad++;
         if (!prev_we && nWE) begin
            dout_rise = DataOut;
            en_rise = {DataOEHi, DataOELo};
         end
         prev_we = nWE;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int pulses, rise, fall2, sl;
      logic prev_sel, drop;
      logic [3:0] ahi_b;
      nReset = 1'b0; ReqValid = 1'b0; v1 = 1'b0;
      ReqWrite = 1'b0; ReqIO = 1'b0; ReqWord = 1'b0;
      ReqAddr = '0; ReqWData = '0; DataIn = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_nsel", nSel, 1'b1);
      chk("rst_nio", nIO, 1'b1);
      chk("rst_noe_nwe", {nOE, nWE}, 2'b11);
      chk("rst_addr", {AddrHi, AddrLo}, 13'h0);
      chk("rst_dout", DataOut, 16'h0);
      chk("rst_oe", {DataOEHi, DataOELo}, 2'b00);
      chk("rst_resp", {RespValid, RespRData}, 17'h0);
      chk("rst_ready", ReqReady, 1'b1);
      chk("rst_ready_s", rdy_s, 1'b1);
      nReset = 1'b1;
      @(posedge clk); #1;

      txn(1'b1, 1'b1, 1'b1, 20'hFA5C2, 16'h005A, 16'h0);
      chk("iow_lat", lat, 4);
      chk("iow_nio", nio0, 1'b0);
      chk("iow_ahi", ahi0, 4'hC);
      chk("iow_alo", alo0, 9'h002);
      chk("iow_en", en0, 2'b01);
      chk("iow_we_lo", we_lo, 2);
      chk("iow_oe_lo", oe_lo, 0);
      chk("iow_sel_lo", sel_lo, 4);
      chk("iow_dout_rise", dout_rise[7:0], 8'h5A);
      chk("iow_en_rise", en_rise, 2'b01);
      chk("iow_recover_oe", {DataOEHi, DataOELo, nSel}, 3'b001);

      txn(1'b0, 1'b1, 1'b1, 20'h000E2, 16'h0, 16'hAB81);
      chk("ior_lat", lat, 4);
      chk("ior_oe_lo", oe_lo, 2);
      chk("ior_we_lo", we_lo, 0);
      chk("ior_oe_bad", oe_bad, 0);
      chk("ior_en0", en0, 2'b00);
      chk("ior_addr", {ahi0, alo0}, {4'hE, 9'h002});
      chk("ior_rdata", RespRData, 16'h0081);
      @(posedge clk); #1;
      chk("ior_pulse", RespValid, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("ior_hold", RespRData, 16'h0081);

      txn(1'b0, 1'b0, 1'b1, 20'h20034, 16'h0, 16'h1234);
      chk("mrw_lat", lat, 4);
      chk("mrw_nio", nio0, 1'b1);
      chk("mrw_addr", {ahi0, alo0}, {4'h2, 9'h034});
      chk("mrw_rdata", RespRData, 16'h1234);
      chk("mrw_oe_bad", oe_bad, 0);

      txn(1'b1, 1'b0, 1'b1, 20'h501FF, 16'hBEEF, 16'h0);
      chk("mww_en", en0, 2'b11);
      chk("mww_dout", dout0, 16'hBEEF);
      chk("mww_addr", {ahi0, alo0}, {4'h5, 9'h1FF});
      chk("mww_rdata_kept", RespRData, 16'h1234);

      txn(1'b0, 1'b0, 1'b0, 20'h00100, 16'h0, 16'hCDEF);
      chk("mrb_alo", alo0, 9'h100);
      chk("mrb_rdata", RespRData, 16'h00EF);

      wait_ready();
      ReqWrite = 1'b1; ReqIO = 1'b1; ReqWord = 1'b0;
      ReqAddr = 20'h00010; ReqWData = 16'h0001;
      ReqValid = 1'b1;
      @(posedge clk); #1;
      ReqAddr = 20'h00020; ReqWData = 16'h0002;
      pulses = 0; rise = -1; fall2 = -1;
      prev_sel = 1'b1; ahi_b = 4'h0;
      for (int k = 0; k < 30; k++) begin
         if (RespValid) pulses++;
         if (!prev_sel && nSel && rise < 0) rise = k;
         if (prev_sel && !nSel && rise >= 0 && fall2 < 0) begin
            fall2 = k;
            ahi_b = AddrHi;
         end
         prev_sel = nSel;
         drop = ReqValid && ReqReady;
         @(posedge clk); #1;
         if (drop) ReqValid = 1'b0;
      end
      ReqValid = 1'b0;
      chk("b2b_pulses", pulses, 2);
      chk("b2b_gap", fall2 - rise, 2);
      chk("b2b_second_port", ahi_b, 4'h2);

      wait_ready();
      ReqWrite = 1'b1; ReqIO = 1'b1; ReqWord = 1'b0;
      ReqAddr = 20'h00033; ReqWData = 16'h00AA;
      ReqValid = 1'b1;
      @(posedge clk); #1;
      ReqValid = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_we_pre", nWE, 1'b0);
      #2 nReset = 1'b0;
      #1;
      chk("rst_mid_nwe", nWE, 1'b1);
      chk("rst_mid_nsel", nSel, 1'b1);
      chk("rst_mid_oe", {DataOEHi, DataOELo}, 2'b00);
      @(posedge clk); #1;
      nReset = 1'b1;
      pulses = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (RespValid) pulses++;
      end
      chk("rst_mid_noresp", pulses, 0);
      chk("rst_mid_ready", ReqReady, 1'b1);

      ReqWrite = 1'b0; ReqIO = 1'b0; ReqWord = 1'b1;
      ReqAddr = 20'h10000; DataIn = 16'h4321;
      v1 = 1'b1;
      @(posedge clk); #1;
      v1 = 1'b0;
      lat = -1; sl = 0;
      for (int k = 0; k < 40; k++) begin
         if (resp_s) begin
            lat = k;
            break;
         end
         if (!nsel_s) sl++;
         @(posedge clk); #1;
      end
      chk("sweep_lat", lat, 9);
      chk("sweep_sel_lo", sl, 9);
      chk("sweep_rdata", rdata_s, 16'h4321);
      @(posedge clk); #1;
      chk("sweep_ready_busy", rdy_s, 1'b0);
      @(posedge clk); #1;
      chk("sweep_ready_back", rdy_s, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
